// File: rtl/key_expansion.sv
// AES-128 key schedule generator.
// Expands one cipher key into w[0..43], one word per clock.
module key_expansion #(
   parameter int N  = 128,
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [N-1:0]                key_in,
   output logic [32*Nk*(Nr+1)-1:0]     word,
   output logic                        busy,
   output logic                        done,
   output logic                        word_valid
);

   localparam int NW = Nk * (Nr + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXPAND = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   logic [1:0]  state_q, state_d;
   logic [5:0]  i_q, i_d;
   logic        valid_q, valid_d;
   logic [31:0] w_q [NW];

   logic        load;
   logic [5:0]  eidx;
   logic [31:0] prev_w, back_w, rot_w, sub_w, temp_w, new_w;
   logic [7:0]  rcon;

   // A start is taken whenever no expansion is running.
   assign load = start && (state_q == IDLE || state_q == DONE);

   // Round function producing the word at the current index.
   always_comb begin
      eidx = 6'd4;
      if (i_q >= 6'd4 && i_q < 6'd44) eidx = i_q;
      prev_w = w_q[eidx - 6'd1];
      back_w = w_q[eidx - 6'd4];
      rot_w  = {prev_w[23:0], prev_w[31:24]};
      sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
      case (eidx[5:2])
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
      if (eidx[1:0] == 2'd0) temp_w = sub_w ^ {rcon, 24'h0};
      else                   temp_w = prev_w;
      new_w = back_w ^ temp_w;
   end

   // Sequencing of the IDLE/EXPAND/DONE controller and index.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      valid_d = valid_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = EXPAND;
               i_d     = 6'd4;
               valid_d = 1'b0;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         EXPAND: begin
            i_d = i_q + 6'd1;
            if (i_q == 6'd43) begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= 6'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         valid_q <= valid_d;
      end
   end

   // Schedule storage: key load on start, then one word per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
      end else if (load) begin
         for (int j = 0; j < Nk; j++) w_q[j] <= key_in[N-1-32*j -: 32];
      end else if (state_q == EXPAND) begin
         w_q[eidx] <= new_w;
      end
   end

   for (genvar g = 0; g < NW; g++) begin : g_pack
      assign word[32*(NW-g)-1 -: 32] = w_q[g];
   end

   assign busy       = (state_q == EXPAND);
   assign done       = (state_q == DONE);
   assign word_valid = valid_q;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion.
// Reference schedule is derived from GF(2^8) arithmetic.
module tb_key_expansion;

   localparam logic [127:0] KF = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [127:0]  key_in = '0;
   logic [1407:0] word;
   logic          busy, done, word_valid;

   int checks = 0;
   int errors = 0;

   logic [7:0]  sb [256];
   logic [31:0] m_sched [44];
   logic [31:0] m_word [44];
   bit          m_run = 0;
   bit          m_done = 0;
   bit          m_valid = 0;
   int          m_k = 0;
   bit          cmp_en = 0;

   key_expansion dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
      .word(word), .busy(busy), .done(done), .word_valid(word_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r = v;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                 ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] k);
      logic [7:0]  rc = 8'h01;
      logic [31:0] t;
      for (int j = 0; j < 4; j++) m_sched[j] = k[127-32*j -: 32];
      for (int j = 4; j < 44; j++) begin
         t = m_sched[j-1];
         if (j % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         m_sched[j] = m_sched[j-4] ^ t;
      end
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model of the schedule as it appears over time.
   initial begin
      for (int j = 0; j < 44; j++) m_word[j] = 32'h0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_run = 0; m_done = 0; m_valid = 0; m_k = 0;
            for (int j = 0; j < 44; j++) m_word[j] = 32'h0;
         end else if (m_run) begin
            m_word[m_k] = m_sched[m_k];
            m_k++;
            if (m_k == 44) begin
               m_run = 0; m_done = 1; m_valid = 1;
            end
         end else if (start) begin
            expand_key(key_in);
            for (int j = 0; j < 4; j++) m_word[j] = m_sched[j];
            m_k = 4; m_run = 1; m_done = 0; m_valid = 0;
         end else begin
            m_done = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("busy", 128'(busy), 128'(m_run));
            chk("done", 128'(done), 128'(m_done));
            chk("word_valid", 128'(word_valid), 128'(m_valid));
            checks++;
            for (int j = 0; j < 44; j++) begin
               if (word[1407-32*j -: 32] !== m_word[j]) begin
                  errors++;
                  $display("FAIL word w[%0d]: got %h expected %h",
                           j, word[1407-32*j -: 32], m_word[j]);
                  break;
               end
            end
         end
      end
   end

   task automatic run_key(input logic [127:0] k, input bit restart10,
                          input logic [31:0] w4, input logic [127:0] last);
      key_in = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      chk("busy after start", 128'(busy), 128'd1);
      chk("valid after start", 128'(word_valid), 128'd0);
      for (int e = 1; e < 40; e++) begin
         if (restart10 && e == 10) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk("done before E40", 128'(done), 128'd0);
      tick();
      chk("done after E40", 128'(done), 128'd1);
      chk("busy in DONE", 128'(busy), 128'd0);
      chk("valid in DONE", 128'(word_valid), 128'd1);
      chk("w4", 128'(word[1279:1248]), 128'(w4));
      chk("last round key", word[127:0], last);
      tick();
      chk("done pulse ends", 128'(done), 128'd0);
      chk("valid in IDLE", 128'(word_valid), 128'd1);
   endtask

   initial begin
      build_sbox();
      chk("model sbox 00", 128'(sb[0]), 128'h63);
      chk("model sbox 53", 128'(sb[8'h53]), 128'hed);
      expand_key(KF);
      chk("model fips w4", 128'(m_sched[4]), 128'ha0fafe17);
      chk("model fips w43", 128'(m_sched[43]), 128'hb6630ca6);
      #1;
      chk("reset busy", 128'(busy), 128'd0);
      chk("reset done", 128'(done), 128'd0);
      chk("reset valid", 128'(word_valid), 128'd0);
      chk("reset word", 128'(|word), 128'd0);
      #2;
      rst_n = 1'b1;
      cmp_en = 1;

      run_key(KF, 0, 32'ha0fafe17, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("fips round 1", word[1279:1152],
          128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips round 0", word[1407:1280], KF);

      run_key('0, 0, 32'h62636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      repeat (5) tick();
      chk("valid held idle", 128'(word_valid), 128'd1);

      run_key(KF, 1, 32'ha0fafe17, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      key_in = KF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      chk("abort busy", 128'(busy), 128'd0);
      chk("abort done", 128'(done), 128'd0);
      chk("abort valid", 128'(word_valid), 128'd0);
      chk("abort word", 128'(|word), 128'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (45) tick();
      chk("no done after abort", 128'(done), 128'd0);
      run_key('0, 0, 32'h62636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      key_in = KF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (38) tick();
      start = 1'b1;
      key_in = '0;
      tick();
      tick();
      chk("b2b done", 128'(done), 128'd1);
      chk("b2b fips last", word[127:0],
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();
      start = 1'b0;
      chk("b2b busy", 128'(busy), 128'd1);
      chk("b2b done clear", 128'(done), 128'd0);
      repeat (39) tick();
      chk("b2b not yet done", 128'(done), 128'd0);
      tick();
      chk("b2b second done", 128'(done), 128'd1);
      chk("b2b zero last", word[127:0],
          128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      repeat (3) tick();

      cmp_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
